fpu_addsub_sched: RTL



---
 rtl/fpu_sched_pkg.sv | 32 +++
 rtl/fpu_addsub_sched_arb.sv | 41 ++++
 rtl/fpu_addsub_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg
// Shared definitions for the fpu_addsub_sched issue scheduler:
//   FPU_LAT          default latency of the shared fsub unit
//   OP_SUB / OP_ADD  per-requester operation encoding
//   ID_MAXW/TAG_MAXW widest requester id / tag a tracking entry can carry
//   track_t          one tracking-pipe entry {valid, id, tag}
//   flip_x2()        maps an add onto the subtractor (x1 + x2 == x1 - (-x2))
package fpu_sched_pkg;

    localparam int FPU_LAT = 3;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Entries are sized for the largest configuration (NREQ up to 8,
    // TAGW up to 16); narrower instances zero-extend into them.
    localparam int ID_MAXW  = 3;
    localparam int TAG_MAXW = 16;

    typedef struct packed {
        logic                valid;
        logic [ID_MAXW-1:0]  id;
        logic [TAG_MAXW-1:0] tag;
    } track_t;

    // Sign of operand 2 is inverted for add, NaN included: the block does
    // no arithmetic of its own and leaves all IEEE behaviour to fsub.
    function automatic logic [31:0] flip_x2(input logic op, input logic [31:0] x2);
        return (op == OP_ADD) ? {~x2[31], x2[30:0]} : x2;
    endfunction

endpackage

// File: rtl/fpu_addsub_sched_arb.sv
// rr_arbiter
// Purely combinational round-robin arbiter.
//   req   in   NREQ           request vector
//   last  in   $clog2(NREQ)   index granted most recently
//   gnt   out  NREQ           one-hot grant (all zero when no request)
//   idx   out  $clog2(NREQ)   encoded index of the granted requester
// Priority runs last+1, last+2, ... modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int         p;
        logic [IDW-1:0] pi;
        logic       found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        pi    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            p = int'(last) + k;
            if (p >= NREQ) begin
                p = p - NREQ;
            end
            pi = IDW'(p);
            if (!found && req[pi]) begin
                gnt[pi] = 1'b1;
                idx     = pi;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_sched.sv
// fpu_addsub_sched
// Shares one pipelined single-precision subtractor (fsub, fixed latency LAT)
// among NREQ requesters. Round-robin arbitration, add mapped onto sub by
// inverting the sign of operand 2, and a {valid,id,tag} tracking pipe that
// labels each fsub result on the shared result bus.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (NREQ bits each)
//   req_op                   per requester: 0 = sub, 1 = add
//   req_x1, req_x2           per-requester operands (NREQ x 32)
//   req_tag                  per-requester opaque tag (NREQ x TAGW)
//   fpu_x1, fpu_x2, fpu_rstn to the fsub instance (fpu_rstn = ~rst)
//   fpu_y                    from the fsub instance
//   res_valid/id/tag/y       result bus, no backpressure
//   stat_issue, stat_wait    statistics counters
//
// Build option: define FPU_SCHED_STATS_EN to include the statistics
// counters; otherwise stat_issue and stat_wait are tied to 0.
//
// Handshake: a request transfers in any cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational from this cycle's
// req_valid and the registered round-robin pointer, is at most one-hot,
// is only raised for a valid requester, and is forced low during reset.
// A requester may drop req_valid in the cycle after its grant.
module fpu_addsub_sched
    import fpu_sched_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int LAT  = FPU_LAT,
    parameter  int TAGW = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ-1:0][31:0]     req_x1,
    input  logic [NREQ-1:0][31:0]     req_x2,
    input  logic [NREQ-1:0][TAGW-1:0] req_tag,
    output logic [31:0]               fpu_x1,
    output logic [31:0]               fpu_x2,
    output logic                      fpu_rstn,
    input  logic [31:0]               fpu_y,
    output logic                      res_valid,
    output logic [IDW-1:0]            res_id,
    output logic [TAGW-1:0]           res_tag,
    output logic [31:0]               res_y,
    output logic [31:0]               stat_issue,
    output logic [31:0]               stat_wait
);

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  last_q, last_d;
    logic            hs;

    // Operand registers; track_q[0] is the entry captured alongside them,
    // track_q[LAT] lines up with fpu_y.
    logic [31:0] x1_q, x1_d;
    logic [31:0] x2_q, x2_d;
    track_t      track_q [LAT+1];
    track_t      ent_d;
    logic        unused_pad;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign req_ready = rst ? '0 : gnt;
    assign hs        = |req_ready;

    always_comb begin
        x1_d       = x1_q;
        x2_d       = x2_q;
        last_d     = last_q;
        ent_d      = track_q[0];
        ent_d.valid = 1'b0;
        if (hs) begin
            x1_d        = req_x1[gnt_idx];
            x2_d        = flip_x2(req_op[gnt_idx], req_x2[gnt_idx]);
            last_d      = gnt_idx;
            ent_d.valid = 1'b1;
            ent_d.id    = ID_MAXW'(gnt_idx);
            ent_d.tag   = TAG_MAXW'(req_tag[gnt_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q   <= '0;
            x2_q   <= '0;
            // Start pointer at the top so requester 0 wins first.
            last_q <= IDW'(NREQ - 1);
            for (int k = 0; k <= LAT; k++) begin
                track_q[k] <= '0;
            end
        end else begin
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            last_q     <= last_d;
            track_q[0] <= ent_d;
            for (int k = 1; k <= LAT; k++) begin
                track_q[k] <= track_q[k-1];
            end
        end
    end

    assign fpu_x1    = x1_q;
    assign fpu_x2    = x2_q;
    assign fpu_rstn  = ~rst;

    assign res_valid = track_q[LAT].valid;
    assign res_id    = track_q[LAT].id[IDW-1:0];
    assign res_tag   = track_q[LAT].tag[TAGW-1:0];
    assign res_y     = fpu_y;

    // Padding bits above IDW/TAGW are constant zero and intentionally unread.
    assign unused_pad = ^track_q[LAT];

`ifdef FPU_SCHED_STATS_EN
    logic [31:0] issue_q;
    logic [31:0] wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q <= '0;
            wait_q  <= '0;
        end else begin
            if (hs) begin
                issue_q <= issue_q + 32'd1;
            end
            // One count per cycle with any requester left waiting.
            if (|(req_valid & ~req_ready)) begin
                wait_q <= wait_q + 32'd1;
            end
        end
    end

    assign stat_issue = issue_q;
    assign stat_wait  = wait_q;
`else
    assign stat_issue = '0;
    assign stat_wait  = '0;
`endif

endmodule
